// File: rtl/xor_parity_pkg.sv
// Shared types for the XOR parity scheduler: FSM state encoding and the
// saturating beat-length type.
package xor_parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned LEN_W = 8;

  typedef logic [LEN_W-1:0] len_t;

  localparam len_t LEN_MAX = len_t'(255);

  // Beat counter increment that sticks at LEN_MAX instead of wrapping
  function automatic len_t len_inc_sat(input len_t len);
    return (len == LEN_MAX) ? len : len + len_t'(1);
  endfunction

endpackage

// File: rtl/xor_parity_rr_arb.sv
// Combinational round-robin arbiter: searches upward from last_id+1 (mod NREQ)
// and returns the first active requester.
module xor_parity_rr_arb
  import xor_parity_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_id_i,
  output logic [IDW-1:0]  gnt_id_c,
  output logic            gnt_any_c
);

  int unsigned idx;

  always_comb begin
    gnt_id_c  = '0;
    gnt_any_c = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(last_id_i) + 32'd1 + k) % NREQ;
      if (!gnt_any_c && req_i[IDW'(idx)]) begin
        gnt_any_c = 1'b1;
        gnt_id_c  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/xor_parity_sched.sv
// Round-robin scheduler that XOR-reduces one requester's packet into a column
// word plus parity. Optional stall timeout: define XOR_PARITY_SCHED_TIMEOUT_EN.
module xor_parity_sched
  import xor_parity_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned W    = 11,
  parameter  int unsigned TMO  = 255,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_col,
  output logic              res_par,
  output logic [IDW-1:0]    res_id,
  output logic [LEN_W-1:0]  res_len,
  output logic              res_err
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]  last_id_q, last_id_d;
  logic [W-1:0]    acc_q, acc_d;
  len_t            len_q, len_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_col_q, res_col_d;
  logic            res_par_q, res_par_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  len_t            res_len_q, res_len_d;

  logic [IDW-1:0]  arb_id_c;
  logic            arb_any_c;
  logic [W-1:0]    word_c;
  logic [W-1:0]    acc_nxt_c;
  len_t            len_nxt_c;
  logic            xfer_c;
  logic            last_c;

`ifdef XOR_PARITY_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = (TMO > 0) ? $clog2(TMO + 1) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             res_err_q, res_err_d;
`endif

  xor_parity_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i     (req_valid),
    .last_id_i (last_id_q),
    .gnt_id_c  (arb_id_c),
    .gnt_any_c (arb_any_c)
  );

  // Granted requester's beat; ready_q is only nonzero in BUSY
  assign word_c    = req_data[gnt_q*W +: W];
  assign xfer_c    = ready_q[gnt_q] & req_valid[gnt_q];
  assign last_c    = req_last[gnt_q];
  assign acc_nxt_c = acc_q ^ word_c;
  assign len_nxt_c = len_inc_sat(len_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_id_d   = last_id_q;
    acc_d       = acc_q;
    len_d       = len_q;
    ready_d     = ready_q;
    res_valid_d = res_valid_q;
    res_col_d   = res_col_q;
    res_par_d   = res_par_q;
    res_id_d    = res_id_q;
    res_len_d   = res_len_q;
`ifdef XOR_PARITY_SCHED_TIMEOUT_EN
    tmo_d       = tmo_q;
    res_err_d   = res_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any_c) begin
          state_d = ST_BUSY;
          gnt_d   = arb_id_c;
          acc_d   = '0;
          len_d   = '0;
          ready_d = NREQ'(1) << arb_id_c;
`ifdef XOR_PARITY_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end

      ST_BUSY: begin
        if (xfer_c) begin
          acc_d = acc_nxt_c;
          len_d = len_nxt_c;
`ifdef XOR_PARITY_SCHED_TIMEOUT_EN
          tmo_d = '0;
`endif
          if (last_c) begin
            state_d     = ST_DONE;
            ready_d     = '0;
            res_valid_d = 1'b1;
            res_col_d   = acc_nxt_c;
            res_par_d   = ^acc_nxt_c;
            res_id_d    = gnt_q;
            res_len_d   = len_nxt_c;
`ifdef XOR_PARITY_SCHED_TIMEOUT_EN
            res_err_d   = 1'b0;
`endif
          end
        end
`ifdef XOR_PARITY_SCHED_TIMEOUT_EN
        // Idle cycle: close with the partial result once TMO stalls accumulate
        else if (tmo_q == TMO_W'(TMO - 1)) begin
          state_d     = ST_DONE;
          ready_d     = '0;
          res_valid_d = 1'b1;
          res_col_d   = acc_q;
          res_par_d   = ^acc_q;
          res_id_d    = gnt_q;
          res_len_d   = len_q;
          res_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          last_id_d   = gnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      last_id_q   <= IDW'(NREQ - 1);
      acc_q       <= '0;
      len_q       <= '0;
      ready_q     <= '0;
      res_valid_q <= 1'b0;
      res_col_q   <= '0;
      res_par_q   <= 1'b0;
      res_id_q    <= '0;
      res_len_q   <= '0;
`ifdef XOR_PARITY_SCHED_TIMEOUT_EN
      tmo_q       <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_id_q   <= last_id_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      res_col_q   <= res_col_d;
      res_par_q   <= res_par_d;
      res_id_q    <= res_id_d;
      res_len_q   <= res_len_d;
`ifdef XOR_PARITY_SCHED_TIMEOUT_EN
      tmo_q       <= tmo_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign res_valid = res_valid_q;
  assign res_col   = res_col_q;
  assign res_par   = res_par_q;
  assign res_id    = res_id_q;
  assign res_len   = res_len_q;
`ifdef XOR_PARITY_SCHED_TIMEOUT_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

endmodule
